mem_lane_arbiter: RTL and testbench

MEM_LANE_ARBITER -- requirements
Module: mem_lane_arbiter

---
 rtl/mem_lane_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_lane_arbiter.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/mem_lane_arbiter.sv
// Two-lane round-robin arbiter onto a single synchronous RAM port.
// Each granted access runs ISSUE -> WAIT and ends with a one-cycle rsp_rdy pulse.
module mem_lane_arbiter #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int READ_DELAY  = 2,
    parameter int WRITE_DELAY = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [1:0]            req_oe,
    input  logic [1:0]            req_we,
    input  logic [2*ADDR_W-1:0]   req_addr,
    input  logic [2*DATA_W-1:0]   req_wdata,
    input  logic [7:0]            req_size,
    output logic [2*DATA_W-1:0]   rsp_rdata,
    output logic [1:0]            rsp_rdy,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W-1:0]     mem_mask,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  busy,
    output logic [1:0]            err_conflict
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;

    localparam logic [3:0] RD_DLY = 4'(READ_DELAY);
    localparam logic [3:0] WR_DLY = 4'(WRITE_DELAY);

    logic [1:0]        state_q, state_d;
    logic              grant_q, grant_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [3:0]        size_q, size_d;
    logic              rr_q, rr_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] cap_q, cap_d;
    logic [1:0]        err_q, err_d;

    logic [1:0] pend, conf;
    logic       win, done, fin, issue;

    // Bit b is set when b < size, which saturates to all ones for size >= DATA_W.
    function automatic logic [DATA_W-1:0] size_mask(input logic [3:0] sz);
        logic [DATA_W-1:0] m;
        for (int b = 0; b < DATA_W; b++) m[b] = (b < int'(sz));
        return m;
    endfunction

    for (genvar i = 0; i < 2; i++) begin : g_lane
        assign pend[i] = req_oe[i] ^ req_we[i];
        assign conf[i] = req_oe[i] & req_we[i];
    end

    assign win   = (pend == 2'b11) ? rr_q : pend[1];
    assign done  = (cnt_q == (we_q ? WR_DLY : RD_DLY));
    assign issue = (state_q == ISSUE);
    assign fin   = (state_q == WAIT) && done;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        cap_d   = cap_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                err_d = err_q | conf;
                if (|pend) begin
                    grant_d = win;
                    we_d    = req_we[win];
                    addr_d  = req_addr[win*ADDR_W +: ADDR_W];
                    wdata_d = req_wdata[win*DATA_W +: DATA_W];
                    size_d  = req_size[win*4 +: 4];
                    rr_d    = ~win;
                    cap_d   = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = 4'd1;
                state_d = WAIT;
            end
            WAIT: begin
                // RAM data for the strobe in ISSUE is valid in the first WAIT cycle.
                if (!we_q && cnt_q == 4'd1) cap_d = mem_rdata & size_mask(size_q);
                if (done) state_d = IDLE;
                else      cnt_d   = cnt_q + 4'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            grant_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= '0;
            rr_q    <= 1'b0;
            cnt_q   <= '0;
            cap_q   <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
            cap_q   <= cap_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        rsp_rdata = '0;
        rsp_rdy   = '0;
        if (fin) begin
            rsp_rdy[grant_q]                    = 1'b1;
            rsp_rdata[grant_q*DATA_W +: DATA_W] = cap_q;
        end
    end

    assign mem_en       = issue;
    assign mem_we       = issue & we_q;
    assign mem_addr     = issue ? addr_q : '0;
    assign mem_wdata    = issue ? wdata_q : '0;
    assign mem_mask     = (issue && we_q) ? size_mask(size_q) : '0;
    assign busy         = (state_q != IDLE);
    assign err_conflict = err_q;

endmodule

// File: tb/tb_mem_lane_arbiter.sv
// Directed bench for mem_lane_arbiter: vector table of single-lane accesses plus
// hand-written arbitration, conflict and reset-abort sequences against a small RAM.
module tb_mem_lane_arbiter;
    logic        clock, reset;
    logic [1:0]  req_oe, req_we;
    logic [15:0] req_addr, req_wdata;
    logic [7:0]  req_size;
    logic [15:0] rsp_rdata;
    logic [1:0]  rsp_rdy;
    logic        mem_en, mem_we;
    logic [7:0]  mem_addr, mem_wdata, mem_mask, mem_rdata;
    logic        busy;
    logic [1:0]  err_conflict;

    int checks = 0;
    int errors = 0;

    logic [7:0] ram [256];

    mem_lane_arbiter dut (
        .clock(clock), .reset(reset),
        .req_oe(req_oe), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_size(req_size),
        .rsp_rdata(rsp_rdata), .rsp_rdy(rsp_rdy),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_mask(mem_mask), .mem_rdata(mem_rdata),
        .busy(busy), .err_conflict(err_conflict)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Synchronous RAM; contents reload whenever reset is held low.
    always @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < 256; i++) ram[i] <= 8'(i);
            ram[8'h10] <= 8'hA5;
            ram[8'h20] <= 8'h11;
            ram[8'h21] <= 8'h00;
            ram[8'h22] <= 8'h55;
            ram[8'hFF] <= 8'h83;
            mem_rdata  <= 8'h00;
        end else if (mem_en) begin
            if (mem_we) ram[mem_addr] <= (ram[mem_addr] & ~mem_mask) | (mem_wdata & mem_mask);
            else        mem_rdata <= ram[mem_addr];
        end
    end

    typedef struct {
        int         lane;
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [3:0] size;
        logic [7:0] mask;
        logic [7:0] rdata;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic clear_req();
        req_oe = '0; req_we = '0; req_addr = '0; req_wdata = '0; req_size = '0;
    endtask

    function automatic logic [63:0] issue_vec(logic we, logic [7:0] a, logic [7:0] d, logic [7:0] m);
        return 64'({1'b1, we, a, d, m});
    endfunction

    function automatic logic [63:0] all_out();
        return 64'({rsp_rdata, rsp_rdy, mem_en, mem_we, mem_addr, mem_wdata, mem_mask, busy, err_conflict});
    endfunction

    // Called at a negedge in IDLE; returns at a negedge in IDLE.
    task automatic run_txn(input string nm, input vec_t v);
        logic [15:0] er;
        int lat;
        clear_req();
        if (v.we) req_we[v.lane] = 1'b1; else req_oe[v.lane] = 1'b1;
        req_addr[v.lane*8 +: 8]  = v.addr;
        req_wdata[v.lane*8 +: 8] = v.wdata;
        req_size[v.lane*4 +: 4]  = v.size;
        tick(1);
        chk({nm, " issue"}, 64'({mem_en, mem_we, mem_addr, mem_wdata, mem_mask}),
            issue_vec(v.we, v.addr, v.wdata, v.mask));
        clear_req();
        lat = v.we ? 1 : 2;
        for (int k = 1; k <= lat; k++) begin
            tick(1);
            if (k < lat) chk({nm, " early rdy"}, 64'(rsp_rdy), 64'd0);
        end
        if (v.we) chk({nm, " rdy"}, 64'(rsp_rdy), 64'(2'b01 << v.lane));
        else begin
            er = '0;
            er[v.lane*8 +: 8] = v.rdata;
            chk({nm, " rsp"}, 64'({rsp_rdy, rsp_rdata}), 64'({2'(2'b01 << v.lane), er}));
        end
        tick(1);
        chk({nm, " idle"}, 64'({busy, rsp_rdy}), 64'd0);
    endtask

    initial begin
        tbl[0]  = '{0, 1'b0, 8'h10, 8'h00, 4'd8,  8'h00, 8'hA5};
        tbl[1]  = '{0, 1'b0, 8'h10, 8'h00, 4'd4,  8'h00, 8'h05};
        tbl[2]  = '{1, 1'b1, 8'h20, 8'h3C, 4'd8,  8'hFF, 8'h00};
        tbl[3]  = '{1, 1'b0, 8'h20, 8'h00, 4'd8,  8'h00, 8'h3C};
        tbl[4]  = '{0, 1'b1, 8'h21, 8'hFF, 4'd3,  8'h07, 8'h00};
        tbl[5]  = '{1, 1'b0, 8'h21, 8'h00, 4'd15, 8'h00, 8'h07};
        tbl[6]  = '{0, 1'b1, 8'h22, 8'hAA, 4'd0,  8'h00, 8'h00};
        tbl[7]  = '{0, 1'b0, 8'h22, 8'h00, 4'd8,  8'h00, 8'h55};
        tbl[8]  = '{1, 1'b0, 8'hFF, 8'h00, 4'd1,  8'h00, 8'h01};
        tbl[9]  = '{0, 1'b1, 8'hFF, 8'h0F, 4'd12, 8'hFF, 8'h00};
        tbl[10] = '{1, 1'b0, 8'hFF, 8'h00, 4'd8,  8'h00, 8'h0F};

        reset = 1'b0;
        clear_req();
        tick(3);
        chk("reset outputs", all_out(), 64'd0);
        reset = 1'b1;

        // Both lanes read: lane 0 first, then lane 1, then lane 0 again.
        req_oe = 2'b11; req_addr = {8'h20, 8'h10}; req_size = 8'h88;
        tick(1); chk("rr0 issue", 64'({mem_en, mem_we, mem_addr, mem_wdata, mem_mask}), issue_vec(1'b0, 8'h10, 8'h00, 8'h00));
        tick(1); chk("rr0 early", 64'(rsp_rdy), 64'd0);
        tick(1); chk("rr0 rsp", 64'({rsp_rdy, rsp_rdata}), 64'({2'b01, 16'h00A5}));
        req_oe = 2'b10;
        tick(1); chk("rr gap idle", 64'(busy), 64'd0);
        tick(1); chk("rr1 issue", 64'({mem_en, mem_we, mem_addr, mem_wdata, mem_mask}), issue_vec(1'b0, 8'h20, 8'h00, 8'h00));
        tick(2); chk("rr1 rsp", 64'({rsp_rdy, rsp_rdata}), 64'({2'b10, 16'h1100}));
        req_oe = 2'b11;
        tick(1); chk("rr2 idle", 64'(busy), 64'd0);
        tick(1); chk("rr2 issue lane0", 64'({mem_en, mem_we, mem_addr, mem_wdata, mem_mask}), issue_vec(1'b0, 8'h10, 8'h00, 8'h00));
        clear_req();
        tick(2); chk("rr2 rsp (dropped req)", 64'({rsp_rdy, rsp_rdata}), 64'({2'b01, 16'h00A5}));
        tick(1);

        // Lane 0 drives oe and we together while lane 1 reads.
        req_oe = 2'b11; req_we = 2'b01; req_addr = {8'h10, 8'h77}; req_size = 8'h88;
        tick(1);
        chk("conflict flag", 64'(err_conflict), 64'd1);
        chk("conflict issue", 64'({mem_en, mem_we, mem_addr, mem_wdata, mem_mask}), issue_vec(1'b0, 8'h10, 8'h00, 8'h00));
        clear_req();
        tick(2); chk("conflict rsp", 64'({rsp_rdy, rsp_rdata}), 64'({2'b10, 16'hA500}));
        tick(1);

        for (int i = 0; i < 11; i++) run_txn($sformatf("vec%0d", i), tbl[i]);
        chk("conflict sticky", 64'(err_conflict), 64'd1);

        // Reset asserted in WAIT of a read aborts it without a response.
        req_oe = 2'b01; req_addr = 16'h0010; req_size = 8'h08;
        tick(1); clear_req();
        tick(1);
        chk("pre-abort busy", 64'(busy), 64'd1);
        reset = 1'b0;
        #1 chk("async reset outputs", all_out(), 64'd0);
        tick(1); chk("abort no rdy", 64'({rsp_rdy, busy}), 64'd0);
        reset = 1'b1;
        run_txn("post reset", tbl[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
